// File: rtl/int_wb_arbiter_pkg.sv
// int_wb_arbiter_pkg: shared writeback payload type and helpers for the integer writeback path
package int_wb_arbiter_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef struct packed {
    logic [5:0]  robIdx;
    logic        iprd_wen;
    logic [6:0]  iprd_idx;
    logic [63:0] wb_data;
    logic        use_imm;
    logic [3:0]  immBIdx;
  } wbInfo_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/int_wb_arbiter_select.sv
// rr_select_n: combinational round-robin pick of up to NUM_GNT requesters starting at ptr
module rr_select_n
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_GNT = 2,
  localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_GNT-1:0] gnt_vld,
  output logic [PTR_W-1:0]   gnt_idx [NUM_GNT],
  output logic [PTR_W-1:0]   next_ptr
);
  int cnt;
  int s;
  // ptr is always < NUM_REQ, so one conditional subtract replaces a modulo
  always_comb begin
    gnt = '0;
    gnt_vld = '0;
    gnt_idx = '{default: '0};
    next_ptr = ptr;
    cnt = 0;
    s = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      s = int'(ptr) + j;
      s = (s >= NUM_REQ) ? s - NUM_REQ : s;
      if (req[s] && cnt < NUM_GNT) begin
        gnt[s] = TRUE;
        gnt_vld[cnt] = TRUE;
        gnt_idx[cnt] = PTR_W'(s);
        next_ptr = PTR_W'(wrap_inc(s, NUM_REQ));
        cnt = cnt + 1;
      end
    end
  end
endmodule

// File: rtl/int_wb_arbiter.sv
// int_wb_arbiter: round-robin mapping of FU completions onto registered writeback ports
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int NUM_WB = 2,
  localparam int PTR_W = NUM_FU > 1 ? $clog2(NUM_FU) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FU-1:0] i_fu_complete,
  input  wbInfo_t           i_fu_wbInfo [NUM_FU],
  output logic [NUM_FU-1:0] o_fu_wb_stall,
  output logic [NUM_WB-1:0] o_wb_vld,
  output wbInfo_t           o_wbInfo [NUM_WB],
  output logic [31:0]       o_stall_cycles
);
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [NUM_FU-1:0] gnt;
  logic [NUM_WB-1:0] gnt_vld;
  logic [PTR_W-1:0]  gnt_idx [NUM_WB];
  rr_select_n #(.NUM_REQ(NUM_FU), .NUM_GNT(NUM_WB)) u_sel (
    .req(i_fu_complete),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx),
    .next_ptr(next_ptr)
  );
  assign o_fu_wb_stall = i_fu_complete & ~gnt;
  // unused ports keep their stale payload; only the valid bit matters downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      o_wb_vld <= '0;
      o_wbInfo <= '{default: '0};
      o_stall_cycles <= '0;
    end else begin
      rr_ptr <= next_ptr;
      o_wb_vld <= gnt_vld;
      for (int k = 0; k < NUM_WB; k++)
        if (gnt_vld[k]) o_wbInfo[k] <= i_fu_wbInfo[gnt_idx[k]];
      if (|o_fu_wb_stall && ~&o_stall_cycles) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
endmodule

// File: doc/int_wb_arbiter.md
Name: int_wb_arbiter

Overview:
- Integer writeback arbiter directly downstream of the single-cycle FUs (ALU, misc/branch units); consumes each FU's registered o_complete/o_wbInfo and returns its i_wb_stall.
- Maps up to NUM_FU completing FUs onto NUM_WB regfile/ROB writeback ports with round-robin fairness.
- Registers the winners for one cycle to drive regfile write, ROB completion and the fast bypass network.

Parameters:
- NUM_FU, 4, number of FU writeback requesters.
- NUM_WB, 2, number of writeback ports; 1 <= NUM_WB <= NUM_FU.
- PTR_W, $clog2(NUM_FU), round-robin pointer width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_fu_complete  in  NUM_FU  per-FU result valid; held stable while that FU's stall is high.
- i_fu_wbInfo  in  wbInfo_t[NUM_FU]  per-FU result (robIdx, iprd_wen, iprd_idx, wb_data, use_imm, immBIdx).
- o_fu_wb_stall  out  NUM_FU  to FU i_wb_stall; FU must hold its output when high.
- o_wb_vld  out  NUM_WB  registered writeback valid per port.
- o_wbInfo  out  wbInfo_t[NUM_WB]  registered writeback payload per port.
- o_stall_cycles  out  32  perf counter: cycles with at least one FU stalled; saturating.

Behaviour:
- Reset (async, rst=1):
  - o_wb_vld=0 and o_wbInfo=0 on all ports.
  - rr_ptr=0; o_stall_cycles=0.
  - o_fu_wb_stall is combinational and evaluates to 0 while every i_fu_complete=0.
- Grant, combinational, same cycle:
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - The first NUM_WB FUs with i_fu_complete=1 are granted.
  - The k-th granted FU in scan order goes to port k.
- o_fu_wb_stall[i] = i_fu_complete[i] & ~granted[i]. A non-requesting FU never sees stall.
- Results with iprd_wen=0 (branches, stores) still consume a port, because the ROB needs completion.
- Writeback register, updated every cycle, latency 1:
  - Port k takes o_wb_vld[k]=1 and o_wbInfo[k]=the granted FU's wbInfo.
  - Unused ports get o_wb_vld=0; their o_wbInfo holds its previous value (don't-care).
  - No downstream backpressure: regfile and ROB always accept.
- rr_ptr update:
  - If any grant occurs, rr_ptr <= (index of the last granted FU + 1) mod NUM_FU. Wrap must be correct when NUM_FU is not a power of 2.
  - No requests: rr_ptr unchanged.
- Fairness guarantee: a continuously requesting FU is granted within ceil(NUM_FU/NUM_WB) cycles.
- Requests <= NUM_WB: all are granted, there is no stall, and the port order follows scan order.
- A stalled FU's request persists unchanged. No duplicate writeback can occur, because a FU is granted at most once per request.
- Reset mid-operation: in-flight o_wb_vld is dropped immediately (async). After deassert, arbitration restarts at rr_ptr=0.
- o_stall_cycles increments when |o_fu_wb_stall, and saturates at 32'hFFFF_FFFF.
- Single-FU case (NUM_FU=1): rr_ptr is constant 0.

Decomposition:
- Shared package (existing fu_define/core package): wbInfo_t, XDEF/WDEF macros, true/false constants.
- Sub-module rr_select_n:
  - Parameters NUM_REQ, NUM_GNT.
  - Inputs: req vector and rotate pointer.
  - Outputs: grant vector, per-grant index list, next pointer.
  - Purely combinational and reusable by the issue-queue select.
- The top module holds rr_ptr, the output registers and the perf counter.

Test Plan:
- Reset, then a single request: rst pulse; FU2 complete, robIdx=5 -> next cycle o_wb_vld=2'b01, o_wbInfo[0].robIdx=5. o_fu_wb_stall=0 throughout; rr_ptr=3.
- Oversubscription: rr_ptr=0, all 4 FUs complete and held.
  - Cycle 0: grant FU0 and FU1, stall=4'b1100, rr_ptr becomes 2.
  - Cycle 1: grant FU2 and FU3, stall=0.
  - o_stall_cycles=1.
- Wrap-around: rr_ptr=3, FU0, FU1 and FU3 request -> FU3 goes to port 0 and FU0 to port 1, FU1 stalled; rr_ptr becomes 1 and FU1 is granted the next cycle.
- Non-writing result: a misc branch with iprd_wen=0 competes with ALU results -> it takes a port and o_wbInfo shows iprd_wen=0. Fairness is unchanged.
- Async reset mid-traffic: assert rst between clock edges while o_wb_vld=2'b11 -> o_wb_vld=0 immediately without a clock edge. After release, FU0 and FU3 requesting -> FU0 is on port 0 (rr_ptr=0).
- Counter saturation: force o_stall_cycles to 32'hFFFF_FFFE, then 3 stall cycles -> the counter holds at 32'hFFFF_FFFF.
